// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional build macro: MULDIV_EARLY_OUT_EN. When it is defined, a divide
// whose dividend magnitude is below the divisor magnitude finishes in one cycle.
package muldiv_sequencer_pkg;

  localparam int OPERAND_WIDTH = 32;
  localparam int MULDIV_LATENCY = OPERAND_WIDTH + 2;
  localparam logic RESET = 1'b0;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_XOR  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_AND  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_MUL  = 5'd10,
    ALU_MULU = 5'd11,
    ALU_DIV  = 5'd12,
    ALU_DIVU = 5'd13,
    ALU_REM  = 5'd14,
    ALU_REMU = 5'd15
  } alu_operation_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } muldiv_state_type;

  function automatic logic is_muldiv_op(input alu_operation_type op);
    case (op)
      ALU_MUL, ALU_MULU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input alu_operation_type op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_div_op(input alu_operation_type op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input alu_operation_type op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulators and one-bit-per-cycle shift-add / restoring shift-subtract step.
// acc_hi holds the product high word or the partial remainder; acc_lo holds
// the product low word or the dividend being shifted into the quotient.
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              fixup,
  input  logic              fast,
  input  logic [WIDTH-1:0]  fast_value,
  input  alu_operation_type op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  output logic [WIDTH-1:0]  result
);

  alu_operation_type op_reg;
  logic              neg_quo_reg;
  logic              neg_rem_reg;
  logic [WIDTH-1:0]  mag_b_reg;
  logic [WIDTH-1:0]  acc_hi_reg;
  logic [WIDTH-1:0]  acc_lo_reg;
  logic [WIDTH-1:0]  result_reg;

  logic              signed_div;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic              div_ge;
  logic [WIDTH-1:0]  div_diff;
  logic [WIDTH-1:0]  acc_hi_next;
  logic [WIDTH-1:0]  acc_lo_next;
  logic [WIDTH-1:0]  fixup_value;

  // Operand magnitudes at load: only signed divides strip the sign, multiplies
  // work on raw bits since just the unsigned product words are returned.
  always_comb begin
    signed_div = is_signed_div_op(op);
    mag_a      = (signed_div && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    mag_b      = (signed_div && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  end

  // One iteration of either the multiply or the divide recurrence.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mag_b_reg} : '0);
    div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_b_reg};
    // The remainder after a successful subtract is below the divisor, so the
    // low WIDTH bits of the difference are exact.
    div_diff  = div_shift[WIDTH-1:0] - mag_b_reg;
    if (is_div_op(op_reg)) begin
      acc_hi_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
      acc_lo_next = {acc_lo_reg[WIDTH-2:0], div_ge};
    end else begin
      acc_hi_next = mul_sum[WIDTH:1];
      acc_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
    end
  end

  // Final word selection with sign correction for signed divides.
  always_comb begin
    case (op_reg)
      ALU_MUL:           fixup_value = acc_lo_reg;
      ALU_MULU:          fixup_value = acc_hi_reg;
      ALU_DIV, ALU_DIVU: fixup_value = neg_quo_reg ? -acc_lo_reg : acc_lo_reg;
      ALU_REM, ALU_REMU: fixup_value = neg_rem_reg ? -acc_hi_reg : acc_hi_reg;
      default:           fixup_value = '0;
    endcase
  end

  // Accumulator, latched-operand and result registers.
  always_ff @(posedge clk) begin
    if (reset == RESET) begin
      op_reg      <= ALU_ADD;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      mag_b_reg   <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      result_reg  <= '0;
    end else begin
      if (load) begin
        op_reg      <= op;
        neg_quo_reg <= signed_div && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        neg_rem_reg <= signed_div && operand_a[WIDTH-1];
        mag_b_reg   <= mag_b;
        acc_hi_reg  <= '0;
        acc_lo_reg  <= mag_a;
      end else if (step) begin
        acc_hi_reg  <= acc_hi_next;
        acc_lo_reg  <= acc_lo_next;
      end
      if (fast) begin
        result_reg <= fast_value;
      end else if (fixup) begin
        result_reg <= fixup_value;
      end
    end
  end

  assign result = result_reg;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle M-extension controller: handshake, FSM, iteration counter and
// divide corner-case fast path. Arithmetic lives in muldiv_datapath.
// Optional build macro: MULDIV_EARLY_OUT_EN (divide with |a| < |b| finishes early).
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  alu_operation_type op_i,
  input  logic [WIDTH-1:0]  operand_a_i,
  input  logic [WIDTH-1:0]  operand_b_i,
  input  logic              kill_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [WIDTH-1:0]  result_o
);

  muldiv_state_type state_reg;
  logic [CNT_W-1:0] count_reg;
  logic             done_reg;

  logic             accept;
  logic             fast_hit;
  logic [WIDTH-1:0] fast_value;
  logic             div_op;
  logic             rem_op;
  logic             sdiv_op;

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] ea_mag_a;
  logic [WIDTH-1:0] ea_mag_b;
`endif

  assign ready_o = (state_reg == IDLE) || (state_reg == DONE);
  assign accept  = start_i && ready_o && is_muldiv_op(op_i) && !kill_i;
  assign busy_o  = (state_reg == CALC) || (state_reg == FIXUP) || accept;
  assign done_o  = done_reg;

  // Detect results that need no iteration: divide by zero, signed overflow
  // and (optionally) a dividend smaller than the divisor.
  always_comb begin
    div_op     = is_div_op(op_i);
    rem_op     = is_rem_op(op_i);
    sdiv_op    = is_signed_div_op(op_i);
    fast_hit   = 1'b0;
    fast_value = '0;
`ifdef MULDIV_EARLY_OUT_EN
    ea_mag_a   = (sdiv_op && operand_a_i[WIDTH-1]) ? -operand_a_i : operand_a_i;
    ea_mag_b   = (sdiv_op && operand_b_i[WIDTH-1]) ? -operand_b_i : operand_b_i;
`endif
    if (div_op && (operand_b_i == '0)) begin
      fast_hit   = 1'b1;
      fast_value = rem_op ? operand_a_i : '1;
    end else if (sdiv_op && (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (operand_b_i == '1)) begin
      fast_hit   = 1'b1;
      fast_value = rem_op ? '0 : operand_a_i;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (div_op && (ea_mag_a < ea_mag_b)) begin
      fast_hit   = 1'b1;
      fast_value = rem_op ? operand_a_i : '0;
    end
`endif
  end

  // Control FSM with iteration counter and registered done pulse.
  always_ff @(posedge clk) begin
    if (reset == RESET) begin
      state_reg <= IDLE;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            if (fast_hit) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= CALC;
              count_reg <= CNT_W'(WIDTH - 1);
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        CALC: begin
          if (kill_i) begin
            state_reg <= IDLE;
          end else if (count_reg == '0) begin
            state_reg <= FIXUP;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        FIXUP: begin
          if (kill_i) begin
            state_reg <= IDLE;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .step       ((state_reg == CALC) && !kill_i),
    .fixup      ((state_reg == FIXUP) && !kill_i),
    .fast       (accept && fast_hit),
    .fast_value (fast_value),
    .op         (op_i),
    .operand_a  (operand_a_i),
    .operand_b  (operand_b_i),
    .result     (result_o)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, kill, reset, chaining.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 34;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start_i;
  alu_operation_type op_i;
  logic [31:0]       operand_a_i;
  logic [31:0]       operand_b_i;
  logic              kill_i;
  logic              ready_o;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       result_o;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .kill_i      (kill_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle (cycle T) and check it is taken.
  task automatic start_op(input string tag, input alu_operation_type op,
                          input logic [31:0] a, input logic [31:0] b);
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    start_i     = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    check({tag, "_busy_accept"}, 32'(busy_o), 32'd1);
  endtask

  // Advance until done_o, checking latency, continuous busy and result.
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int n = 0;
    int gaps = 0;
    bit seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clk);
      #1;
      start_i     = 1'b0;
      operand_a_i = 32'hDEAD_BEEF;
      operand_b_i = 32'h0BAD_F00D;
      #1;
      n++;
      if (done_o) seen = 1'b1;
      else if (!busy_o) gaps++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy_gaps"}, 32'(gaps), 32'd0);
    check({tag, "_result"}, result_o, exp_res);
  endtask

  task automatic run_op(input string tag, input alu_operation_type op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    start_op(tag, op, a, b);
    wait_done(tag, exp_res, exp_lat);
    step();
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_held"}, result_o, exp_res);
    $display("[TB] %s op=%0d a=0x%08h b=0x%08h result=0x%08h", tag, op, a, b, result_o);
  endtask

  initial begin
    int dones;
    reset       = 1'b0;
    start_i     = 1'b0;
    kill_i      = 1'b0;
    op_i        = ALU_ADD;
    operand_a_i = '0;
    operand_b_i = '0;
    repeat (3) step();
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    reset = 1'b1;
    step();

    run_op("mul_7_m3", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
    run_op("mulu_ff_2", ALU_MULU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, LAT);
    run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, LAT);
    run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, LAT);
    run_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT);
    run_op("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
    run_op("div_5_0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_5_0", ALU_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Non-M op with start is ignored.
    op_i    = ALU_ADD;
    start_i = 1'b1;
    #1;
    check("nonm_busy", 32'(busy_o), 32'd0);
    step();
    start_i = 1'b0;
    #1;
    check("nonm_ready", 32'(ready_o), 32'd1);
    check("nonm_busy_after", 32'(busy_o), 32'd0);
    $display("[TB] nonm ignored ready=%0b busy=%0b", ready_o, busy_o);

    // Kill at T+10 of a DIVU.
    start_op("kill", ALU_DIVU, 32'd1000, 32'd3);
    step();
    start_i = 1'b0;
    repeat (9) step();
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    #1;
    check("kill_ready", 32'(ready_o), 32'd1);
    check("kill_busy", 32'(busy_o), 32'd0);
    dones = 0;
    repeat (40) begin
      step();
      if (done_o) dones++;
    end
    check("kill_no_done", 32'(dones), 32'd0);
    check("kill_result_kept", result_o, 32'h8000_0000);
    $display("[TB] kill dones=%0d result=0x%08h", dones, result_o);

    // Kill together with start: nothing accepted.
    op_i        = ALU_DIVU;
    operand_a_i = 32'd9;
    operand_b_i = 32'd2;
    start_i     = 1'b1;
    kill_i      = 1'b1;
    #1;
    check("killstart_busy", 32'(busy_o), 32'd0);
    step();
    start_i = 1'b0;
    kill_i  = 1'b0;
    #1;
    check("killstart_busy_after", 32'(busy_o), 32'd0);
    dones = 0;
    repeat (40) begin
      step();
      if (done_o) dones++;
    end
    check("killstart_no_done", 32'(dones), 32'd0);
    $display("[TB] kill+start dones=%0d", dones);

    // Back-to-back: second request accepted in the DONE cycle.
    start_op("b2b1", ALU_MULU, 32'h0001_0000, 32'h0001_0000);
    wait_done("b2b1", 32'd1, LAT);
    start_op("b2b2", ALU_DIVU, 32'd100, 32'd7);
    wait_done("b2b2", 32'd14, LAT);
    step();
    check("b2b_done_pulse", 32'(done_o), 32'd0);
    $display("[TB] back-to-back result=0x%08h", result_o);

    // Reset during CALC.
    start_op("rstmid", ALU_DIVU, 32'd50, 32'd3);
    step();
    start_i = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("rstmid_ready", 32'(ready_o), 32'd1);
    check("rstmid_busy", 32'(busy_o), 32'd0);
    check("rstmid_result", result_o, 32'd0);
    dones = 0;
    repeat (40) begin
      step();
      if (done_o) dones++;
    end
    check("rstmid_no_done", 32'(dones), 32'd0);
    $display("[TB] reset mid-op ready=%0b result=0x%08h", ready_o, result_o);

    run_op("divu_3_10", ALU_DIVU, 32'd3, 32'd10, 32'd0, EO_LAT);
    run_op("remu_3_10", ALU_REMU, 32'd3, 32'd10, 32'd3, EO_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle controller for the M-extension ops in alu_operation_type: MUL, MULU, DIV, DIVU, REM and REMU.
- Sits beside the EX-stage ALU. Accepts one op per handshake, runs a radix-2 shift-add or shift-subtract loop, and holds the pipeline via busy_o until it pulses done_o with a registered result.
- Handles RISC-V divide corner cases without iterating.

Parameters:
WIDTH, OPERAND_WIDTH (32), operand and result width
CNT_W, $clog2(WIDTH) (5), iteration counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low; asserted when reset == RESET (1'b0)
start_i  in  1  request; sampled only while ready_o=1
op_i  in  5  alu_operation_type; only MUL/MULU/DIV/DIVU/REM/REMU are accepted
operand_a_i  in  WIDTH  multiplicand or dividend (rs1)
operand_b_i  in  WIDTH  multiplier or divisor (rs2)
kill_i  in  1  flush; aborts the in-flight op
ready_o  out  1  can accept a request this cycle
busy_o  out  1  op in flight; pipeline stall
done_o  out  1  one-cycle pulse; result_o valid
result_o  out  WIDTH  registered result, held until the next done_o

Behaviour:
- Reset values: state=IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, counter=0, accumulators=0. Reset mid-op aborts immediately with no done_o.
- States: IDLE, CALC, FIXUP, DONE.
- ready_o = (state==IDLE || state==DONE).
- busy_o = (state==CALC || state==FIXUP), or acceptance this cycle.
- Acceptance: start_i && ready_o && op is an M op && !kill_i. A non-M op with start_i is ignored and the state does not change.
- At acceptance, latch op, sign flags and magnitudes.
  - DIV/REM: take absolute values.
  - MUL/MULU: operands are unsigned. Low 32 bits are sign-independent, so MUL returns the low word and MULU returns the high word of the unsigned product.
- Fast path at acceptance, going directly to DONE (done_o in cycle T+1):
  - Divisor == 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - DIV with a=0x8000_0000 and b=0xFFFF_FFFF: quotient is 0x8000_0000, REM is 0.
- Normal path:
  - Counter loads WIDTH-1.
  - CALC runs for WIDTH cycles (T+1..T+WIDTH), one bit per cycle. Multiply uses a 2*WIDTH shift-add accumulator. Divide uses restoring shift-subtract with a remainder/quotient pair.
  - Exit CALC when counter==0.
  - FIXUP at T+WIDTH+1 applies sign correction:
    - Quotient is negated if signs differ.
    - Remainder takes the dividend's sign.
    - result_o is registered here.
  - DONE at T+WIDTH+2 pulses done_o. Total latency is 34 cycles for WIDTH=32.
- DONE lasts one cycle, then returns to IDLE unless a new request is accepted in that same cycle (back-to-back accepted, no bubble).
- kill_i in CALC/FIXUP: next state is IDLE and no done_o pulse. result_o keeps its previous value.
- kill_i together with start_i: kill wins and nothing is accepted.
- kill_i in DONE: done_o still pulses this cycle; suppressing it is the consumer's responsibility.
- Operand inputs are don't-care after acceptance.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: for DIV/DIVU/REM/REMU with |a| < |b| (magnitudes, nonzero divisor), take the fast path to DONE. done_o is at T+1, quotient=0, remainder=original dividend.
- Undefined: such ops take the full WIDTH+2 latency and give identical results.

Decomposition:
- Package common gains:
  - typedef enum muldiv_state_type {IDLE, CALC, FIXUP, DONE}
  - localparam MULDIV_LATENCY = OPERAND_WIDTH+2
  - function is_muldiv_op(alu_operation_type)
- Sub-module muldiv_datapath holds the accumulator registers and one-step add/subtract logic, driven by load/step/fixup strobes. The sequencer owns the FSM, counter, fast-path detect and handshake.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFD) -> done_o at T+34, result 0xFFFF_FFEB; busy_o high T..T+33.
- MULU a=0xFFFF_FFFF, b=2 -> result 0x0000_0001. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV -7/2 -> 0xFFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF (-1).
- DIV a=5, b=0 -> done_o at T+1, 0xFFFF_FFFF. REM a=5, b=0 -> 5. DIV 0x8000_0000 by -1 -> 0x8000_0000 at T+1; REM of the same operands -> 0.
- kill_i at T+10 of a DIVU -> IDLE at T+11, no done_o, result_o unchanged. Back-to-back start in the DONE cycle -> second done_o exactly 34 cycles later.
- Reset (reset=0) during CALC -> next cycle ready_o=1, busy_o=0, result_o=0. With MULDIV_EARLY_OUT_EN, DIVU 3/10 -> done_o at T+1, result 0.
